matrix_cfg_sequencer: RTL and testbench

Configuration front-end for one or more recursive coupling matrices. It accepts single-word read and write requests over a valid/ready handshake and decodes them into the matrix write-port signals for a selected tile. Those signals are `wready`, `wr_match`, `s_addr`, `d_addr`, `vh` and `wdata`. It returns read data after a fixed latency and provides a bulk-clear sequencer that walks every cell of every tile. It sits between the AXI register decoder and `TILES` matrix instances.

---
 rtl/matrix_cfg_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_matrix_cfg_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_cfg_sequencer.sv
// rtl/matrix_cfg_sequencer.sv - request decoder, read return and bulk clear for coupling-matrix tiles (optional MATRIX_CFG_SYM_WRITE_EN)
module matrix_cfg_sequencer #(
    parameter int          N          = 8,
    parameter int          TILES      = 2,
    parameter int          RD_LAT     = 2,
    parameter logic [31:0] CLEAR_WORD = 32'h0,
    localparam int         TW         = (TILES > 1) ? $clog2(TILES) : 1,
    localparam int         AW         = $clog2(N) + 1
) (
    input  logic                clk,
    input  logic                axi_rstn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [TW-1:0]       req_tile,
    input  logic [AW-1:0]       req_s,
    input  logic [AW-1:0]       req_d,
    input  logic                req_vh,
    input  logic [31:0]         req_wdata,
    output logic                rsp_valid,
    output logic [31:0]         rsp_rdata,
    input  logic                clear_start,
    output logic                busy,
    output logic                clear_done,
    output logic                m_wready,
    output logic [TILES-1:0]    m_wr_match,
    output logic [AW-1:0]       m_s_addr,
    output logic [AW-1:0]       m_d_addr,
    output logic                m_vh,
    output logic [31:0]         m_wdata,
    input  logic [32*TILES-1:0] m_rdata
);

    localparam int RCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_CLR  = 3'd3,
        S_RSP  = 3'd4
`ifdef MATRIX_CFG_SYM_WRITE_EN
        ,
        S_MIR  = 3'd5
`endif
    } state_t;

    state_t             state_q;
    logic [RCW-1:0]     rd_cnt_q;
    logic [TW-1:0]      tile_q;
    logic               oor_q;
`ifdef MATRIX_CFG_SYM_WRITE_EN
    logic [AW-1:0]      s_q;
    logic [AW-1:0]      d_q;
    logic               vh_q;
`endif
    logic               rsp_valid_q;
    logic [31:0]        rsp_rdata_q;
    logic               clear_done_q;
    logic               m_wready_q;
    logic [TILES-1:0]   m_wr_match_q;
    logic [AW-1:0]      m_s_addr_q;
    logic [AW-1:0]      m_d_addr_q;
    logic               m_vh_q;
    logic [31:0]        m_wdata_q;

    logic               req_oor;
    logic [TILES-1:0]   req_sel;
    logic [31:0]        rd_word;
    logic               clr_last;

    // Decode the incoming request: range check and one-hot tile select
    always_comb begin
        req_sel = '0;
        for (int t = 0; t < TILES; t++) begin
            req_sel[t] = (req_tile == TW'(t));
        end
        req_oor = req_s[AW-1] | req_d[AW-1]
                | ({{(32-TW){1'b0}}, req_tile} >= 32'(TILES));
    end

    // Pick the read word of the tile captured at accept
    always_comb begin
        rd_word = '0;
        for (int t = 0; t < TILES; t++) begin
            if (tile_q == TW'(t)) begin
                rd_word = m_rdata[32*t +: 32];
            end
        end
    end

    assign clr_last = (m_s_addr_q == AW'(N - 1)) && (m_d_addr_q == AW'(N - 1)) && m_vh_q;

    // Sequencer: state plus every registered output
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_q      <= S_IDLE;
            rd_cnt_q     <= '0;
            tile_q       <= '0;
            oor_q        <= 1'b0;
`ifdef MATRIX_CFG_SYM_WRITE_EN
            s_q          <= '0;
            d_q          <= '0;
            vh_q         <= 1'b0;
`endif
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            clear_done_q <= 1'b0;
            m_wready_q   <= 1'b0;
            m_wr_match_q <= '0;
            m_s_addr_q   <= '0;
            m_d_addr_q   <= '0;
            m_vh_q       <= 1'b0;
            m_wdata_q    <= '0;
        end else begin
            rsp_valid_q  <= 1'b0;
            clear_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    m_wready_q   <= 1'b0;
                    m_wr_match_q <= '0;
                    if (clear_start) begin
                        state_q      <= S_CLR;
                        m_wready_q   <= 1'b1;
                        m_wr_match_q <= '1;
                        m_s_addr_q   <= '0;
                        m_d_addr_q   <= '0;
                        m_vh_q       <= 1'b0;
                        m_wdata_q    <= CLEAR_WORD;
                    end else if (req_valid) begin
                        tile_q       <= req_tile;
                        oor_q        <= req_oor;
`ifdef MATRIX_CFG_SYM_WRITE_EN
                        s_q          <= req_s;
                        d_q          <= req_d;
                        vh_q         <= req_vh;
`endif
                        m_s_addr_q   <= req_s;
                        m_d_addr_q   <= req_d;
                        m_vh_q       <= req_vh;
                        m_wdata_q    <= req_wdata;
                        m_wr_match_q <= req_oor ? '0 : req_sel;
                        if (req_we) begin
                            state_q    <= S_WR;
                            m_wready_q <= 1'b1;
                        end else begin
                            state_q    <= S_RD;
                            m_wready_q <= 1'b0;
                            rd_cnt_q   <= RCW'(RD_LAT - 1);
                        end
                    end
                end
                S_WR: begin
`ifdef MATRIX_CFG_SYM_WRITE_EN
                    if (s_q != d_q) begin
                        // Transposed entry keeps J symmetric; strobe and tile select stay up
                        state_q    <= S_MIR;
                        m_s_addr_q <= d_q;
                        m_d_addr_q <= s_q;
                        m_vh_q     <= ~vh_q;
                    end else begin
                        state_q      <= S_RSP;
                        m_wready_q   <= 1'b0;
                        m_wr_match_q <= '0;
                        rsp_valid_q  <= 1'b1;
                        rsp_rdata_q  <= '0;
                    end
`else
                    state_q      <= S_RSP;
                    m_wready_q   <= 1'b0;
                    m_wr_match_q <= '0;
                    rsp_valid_q  <= 1'b1;
                    rsp_rdata_q  <= '0;
`endif
                end
`ifdef MATRIX_CFG_SYM_WRITE_EN
                S_MIR: begin
                    state_q      <= S_RSP;
                    m_wready_q   <= 1'b0;
                    m_wr_match_q <= '0;
                    rsp_valid_q  <= 1'b1;
                    rsp_rdata_q  <= '0;
                end
`endif
                S_RD: begin
                    if (rd_cnt_q == '0) begin
                        state_q      <= S_RSP;
                        m_wr_match_q <= '0;
                        rsp_valid_q  <= 1'b1;
                        rsp_rdata_q  <= oor_q ? 32'hAAAA_AAAA : rd_word;
                    end else begin
                        rd_cnt_q <= rd_cnt_q - RCW'(1);
                    end
                end
                S_CLR: begin
                    if (clr_last) begin
                        state_q      <= S_IDLE;
                        m_wready_q   <= 1'b0;
                        m_wr_match_q <= '0;
                        clear_done_q <= 1'b1;
                    end else if (m_vh_q) begin
                        m_vh_q <= 1'b0;
                        if (m_d_addr_q == AW'(N - 1)) begin
                            m_d_addr_q <= '0;
                            m_s_addr_q <= m_s_addr_q + AW'(1);
                        end else begin
                            m_d_addr_q <= m_d_addr_q + AW'(1);
                        end
                    end else begin
                        m_vh_q <= 1'b1;
                    end
                end
                S_RSP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q      <= S_IDLE;
                    m_wready_q   <= 1'b0;
                    m_wr_match_q <= '0;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !clear_start;
    assign busy       = (state_q != S_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign clear_done = clear_done_q;
    assign m_wready   = m_wready_q;
    assign m_wr_match = m_wr_match_q;
    assign m_s_addr   = m_s_addr_q;
    assign m_d_addr   = m_d_addr_q;
    assign m_vh       = m_vh_q;
    assign m_wdata    = m_wdata_q;

endmodule

// File: tb/tb_matrix_cfg_sequencer.sv
// tb/tb_matrix_cfg_sequencer.sv - scoreboard bench for matrix_cfg_sequencer
module tb_matrix_cfg_sequencer;

    localparam int          N      = 8;
    localparam int          TILES  = 2;
    localparam int          RD_LAT = 2;
    localparam logic [31:0] CW     = 32'h0;
`ifdef MATRIX_CFG_SYM_WRITE_EN
    localparam int          WLAT_M = 2;
    localparam int          NSTR_M = 2;
`else
    localparam int          WLAT_M = 1;
    localparam int          NSTR_M = 1;
`endif

    logic        clk = 1'b0;
    logic        axi_rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [0:0]  req_tile = '0;
    logic [3:0]  req_s = '0;
    logic [3:0]  req_d = '0;
    logic        req_vh = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        clear_start = 1'b0;
    logic        busy;
    logic        clear_done;
    logic        m_wready;
    logic [1:0]  m_wr_match;
    logic [3:0]  m_s_addr;
    logic [3:0]  m_d_addr;
    logic        m_vh;
    logic [31:0] m_wdata;
    logic [63:0] m_rdata = {32'h1234_5678, 32'hDEAD_BEEF};

    matrix_cfg_sequencer #(.N(N), .TILES(TILES), .RD_LAT(RD_LAT), .CLEAR_WORD(CW)) dut (
        .clk(clk), .axi_rstn(axi_rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_tile(req_tile), .req_s(req_s), .req_d(req_d), .req_vh(req_vh),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
        .m_wready(m_wready), .m_wr_match(m_wr_match), .m_s_addr(m_s_addr),
        .m_d_addr(m_d_addr), .m_vh(m_vh), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; time t; } exp_t;
    typedef struct { logic [3:0] s; logic [3:0] d; logic vh; logic [1:0] m; logic [31:0] w; } strobe_t;

    exp_t    exp_q[$];
    strobe_t slog[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    int      sel_cycles = 0;
    int      clr_cnt = 0;
    int      clr_bad = 0;
    int      done_cnt = 0;
    time     last_acc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: strobes, clear walk, clear_done and response scoreboard
    always @(negedge clk) begin
        if (axi_rstn) begin
            if (m_wr_match != 2'b00) sel_cycles++;
            if (m_wready && m_wr_match != 2'b00) begin
                slog.push_back('{m_s_addr, m_d_addr, m_vh, m_wr_match, m_wdata});
                if (m_wr_match == 2'b11) begin
                    if (m_s_addr != 4'(clr_cnt / (2*N)) || m_d_addr != 4'((clr_cnt / 2) % N)
                        || m_vh != 1'(clr_cnt % 2) || m_wdata != CW) clr_bad++;
                    clr_cnt++;
                end
            end
            if (clear_done) begin
                done_cnt++;
                chk("busy_at_clear_done", {31'd0, busy}, 32'd0);
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.d);
                    chk("rsp_time", 32'($time), 32'(e.t));
                end
            end
        end
    end

    task automatic send(input logic we, input logic [0:0] tile, input logic [3:0] s, input logic [3:0] d,
                        input logic vh, input logic [31:0] wd, input logic [31:0] exp, input int lat);
        int n;
        req_we = we; req_tile = tile; req_s = s; req_d = d; req_vh = vh; req_wdata = wd;
        req_valid = 1'b1;
        #1;
        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        last_acc = $time;
        exp_q.push_back('{exp, $time + lat*10 + 5});
        #1 req_valid = 1'b0;
    endtask

    initial begin
        int sc;
        time t1;
        // reset state
        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_clear_done", {31'd0, clear_done}, 32'd0);
        chk("rst_wready", {31'd0, m_wready}, 32'd0);
        chk("rst_match", {30'd0, m_wr_match}, 32'd0);
        chk("rst_addr", {23'd0, m_s_addr, m_d_addr, m_vh}, 32'd0);
        chk("rst_data", m_wdata | rsp_rdata, 32'd0);
        @(negedge clk); axi_rstn = 1'b1;

        // plain write tile 1, s3 d5 vh1 (mirrored when enabled since s!=d)
        @(negedge clk); slog.delete(); sc = sel_cycles;
        send(1'b1, 1'b1, 4'd3, 4'd5, 1'b1, 32'h13, 32'h0, WLAT_M);
        repeat (5) @(negedge clk);
        chk("wr_strobes", 32'(slog.size()), 32'(NSTR_M));
        if (slog.size() > 0) begin
            chk("wr_match", {30'd0, slog[0].m}, 32'h2);
            chk("wr_addr", {23'd0, slog[0].s, slog[0].d, slog[0].vh}, {23'd0, 4'd3, 4'd5, 1'b1});
            chk("wr_data", slog[0].w, 32'h13);
        end
        chk("wr_sel_cycles", 32'(sel_cycles - sc), 32'(NSTR_M));

        // reads of both tiles
        @(negedge clk); slog.delete(); sc = sel_cycles;
        send(1'b0, 1'b0, 4'd2, 4'd6, 1'b0, 32'h0, 32'hDEAD_BEEF, RD_LAT);
        repeat (5) @(negedge clk);
        chk("rd0_no_strobe", 32'(slog.size()), 32'd0);
        chk("rd0_sel_hold", 32'(sel_cycles - sc), 32'(RD_LAT));
        @(negedge clk);
        send(1'b0, 1'b1, 4'd7, 4'd0, 1'b1, 32'h0, 32'h1234_5678, RD_LAT);
        repeat (5) @(negedge clk);

        // symmetric write s1 d4 vh0, then diagonal s=d=2
        @(negedge clk); slog.delete();
        send(1'b1, 1'b0, 4'd1, 4'd4, 1'b0, 32'h77, 32'h0, WLAT_M);
        repeat (5) @(negedge clk);
        chk("sym_strobes", 32'(slog.size()), 32'(NSTR_M));
        if (slog.size() > 1)
            chk("sym_mirror", {23'd0, slog[1].s, slog[1].d, slog[1].vh}, {23'd0, 4'd4, 4'd1, 1'b1});
        @(negedge clk); slog.delete();
        send(1'b1, 1'b0, 4'd2, 4'd2, 1'b0, 32'h88, 32'h0, 1);
        repeat (5) @(negedge clk);
        chk("diag_strobes", 32'(slog.size()), 32'd1);

        // out-of-range requests
        @(negedge clk); slog.delete(); sc = sel_cycles;
        send(1'b0, 1'b0, 4'b1000, 4'd1, 1'b0, 32'h0, 32'hAAAA_AAAA, RD_LAT);
        repeat (5) @(negedge clk);
        @(negedge clk);
        send(1'b0, 1'b1, 4'd1, 4'b1001, 1'b0, 32'h0, 32'hAAAA_AAAA, RD_LAT);
        repeat (5) @(negedge clk);
        @(negedge clk);
        send(1'b1, 1'b1, 4'b1000, 4'd3, 1'b0, 32'h99, 32'h0, WLAT_M);
        repeat (5) @(negedge clk);
        chk("oor_no_sel", 32'(sel_cycles - sc), 32'd0);
        chk("oor_no_strobe", 32'(slog.size()), 32'd0);

        // back-to-back diagonal writes: one every three cycles
        @(negedge clk);
        send(1'b1, 1'b0, 4'd6, 4'd6, 1'b1, 32'h1, 32'h0, 1);
        t1 = last_acc;
        send(1'b1, 1'b1, 4'd5, 4'd5, 1'b0, 32'h2, 32'h0, 1);
        chk("b2b_gap", 32'(last_acc - t1), 32'd30);
        repeat (5) @(negedge clk);

        // clear_start beats a simultaneous request; request accepted after clear
        @(negedge clk); clr_cnt = 0; clr_bad = 0; sc = done_cnt;
        clear_start = 1'b1;
        #1 chk("ready_vs_clear", {31'd0, req_ready}, 32'd0);
        fork
            send(1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 32'h55, 32'h0, WLAT_M);
            begin @(posedge clk); #1 clear_start = 1'b0; end
        join
        chk("clr_strobes", 32'(clr_cnt), 32'(2*N*N));
        chk("clr_walk_errors", 32'(clr_bad), 32'd0);
        chk("clr_done_count", 32'(done_cnt - sc), 32'd1);
        repeat (6) @(negedge clk);

        // reset during clear at entry 40
        @(negedge clk); clr_cnt = 0; clr_bad = 0; sc = done_cnt;
        clear_start = 1'b1;
        @(posedge clk); #1 clear_start = 1'b0;
        for (int i = 0; i < 200 && clr_cnt < 41; i++) begin
            @(negedge clk); #1;
        end
        chk("clr_reached_40", 32'(clr_cnt), 32'd41);
        axi_rstn = 1'b0;
        #1;
        chk("abort_wready", {31'd0, m_wready}, 32'd0);
        chk("abort_match", {30'd0, m_wr_match}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_outs", {23'd0, m_s_addr, m_d_addr, m_vh} | m_wdata | rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        axi_rstn = 1'b1;
        repeat (300) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - sc), 32'd0);
        chk("abort_no_strobes", 32'(clr_cnt), 32'd41);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
